// File: rtl/doorlock_pkg.sv
// Shared door-lock definitions: verifier handshake codes, keypad codes and the
// internal phases of the keypad front end.
package doorlock_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_VERIFY = 2'b01;
    localparam logic [1:0] ST_OPEN   = 2'b10;
    localparam logic [1:0] ST_CHANGE = 2'b11;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CHANGE = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    localparam logic [15:0] DEFAULT_PW = 16'h1234;
    localparam int          PW_DIGITS  = 4;

    typedef enum logic [2:0] {
        S_ENTRY,
        S_VER1,
        S_VER2,
        S_OPEN,
        S_CHG_ENTRY,
        S_COMMIT,
        S_LOCK
    } entry_state_t;

    // Several internal phases share one code on the verifier link.
    function automatic logic [1:0] state_code(input entry_state_t s);
        case (s)
            S_VER1, S_VER2:        return ST_VERIFY;
            S_OPEN, S_CHG_ENTRY:   return ST_OPEN;
            S_COMMIT:              return ST_CHANGE;
            default:               return ST_IDLE;
        endcase
    endfunction

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/pw_digit_buf.sv
// Four-digit BCD entry buffer: shifts digits in from the right, counts them
// and drops anything typed once it is full.
module pw_digit_buf
    import doorlock_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        shift_en,
    input  logic [3:0]  digit,
    input  logic        clear,
    output logic [15:0] buf_word,
    output logic [2:0]  digit_cnt,
    output logic        full
);

    localparam logic [2:0] CNT_MAX = 3'(PW_DIGITS);

    logic [15:0] word_reg;
    logic [2:0]  cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (clear) begin
            word_reg <= '0;
            cnt_reg  <= '0;
        end else if (shift_en && (cnt_reg < CNT_MAX)) begin
            word_reg <= {word_reg[11:0], digit};
            cnt_reg  <= cnt_reg + 3'd1;
        end
    end

    assign buf_word  = word_reg;
    assign digit_cnt = cnt_reg;
    assign full      = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/pw_entry_ctrl.sv
// Keypad front end of the door lock: digit collection, verify handshake with
// password_verifier, door-open timing, password change and failure lockout.
module pw_entry_ctrl
    import doorlock_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000,
    parameter int unsigned MAX_FAIL    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        pw_valid_in,
    output logic [16:0] pwsin,
    output logic [1:0]  current_state,
    output logic        door_open,
    output logic        lockout,
    output logic [2:0]  digit_cnt
);

    localparam int              FAIL_W     = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [31:0]     OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0]     LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

    entry_state_t      state_reg, state_next;
    logic [31:0]       timer_reg, timer_next;
    logic [FAIL_W-1:0] fail_cnt_reg, fail_cnt_next, fail_inc;

    logic        key_digit, key_enter, key_change, key_clear;
    logic        shift_en, buf_clear, buf_full;
    logic [15:0] buf_word;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_enter  = key_valid && (key_code == KEY_ENTER);
    assign key_change = key_valid && (key_code == KEY_CHANGE);
    assign key_clear  = key_valid && (key_code == KEY_CLEAR);

    assign fail_inc = (fail_cnt_reg == FAIL_LIMIT) ? FAIL_LIMIT : fail_cnt_reg + 1'b1;

    pw_digit_buf u_digit_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (shift_en),
        .digit     (key_code),
        .clear     (buf_clear),
        .buf_word  (buf_word),
        .digit_cnt (digit_cnt),
        .full      (buf_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_ENTRY;
            timer_reg    <= '0;
            fail_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            fail_cnt_reg <= fail_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        fail_cnt_next = fail_cnt_reg;
        shift_en      = 1'b0;
        buf_clear     = 1'b0;
        case (state_reg)
            S_ENTRY: begin
                shift_en = key_digit;
                if (key_clear) begin
                    buf_clear = 1'b1;
                end else if (key_enter) begin
                    if (buf_full) state_next = S_VER1;
                    else          buf_clear  = 1'b1;
                end
            end
            S_VER1: state_next = S_VER2;
            S_VER2: begin
                // pw_valid_in was registered by the verifier at the end of VER1.
                buf_clear = 1'b1;
                if (pw_valid_in) begin
                    state_next    = S_OPEN;
                    timer_next    = OPEN_LOAD;
                    fail_cnt_next = '0;
                end else begin
                    fail_cnt_next = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_next = S_LOCK;
                        timer_next = LOCK_LOAD;
                    end else begin
                        state_next = S_ENTRY;
                    end
                end
            end
            S_OPEN: begin
                // CHANGE takes priority over a simultaneous timer expiry.
                if (key_change)               state_next = S_CHG_ENTRY;
                else if (timer_reg == 32'd0)  state_next = S_ENTRY;
                else                          timer_next = timer_reg - 32'd1;
            end
            S_CHG_ENTRY: begin
                shift_en = key_digit;
                if (key_clear) begin
                    buf_clear = 1'b1;
                end else if (key_enter) begin
                    if (buf_full) state_next = S_COMMIT;
                    else          buf_clear  = 1'b1;
                end else if (key_change) begin
                    state_next = S_OPEN;
                    buf_clear  = 1'b1;
                    timer_next = OPEN_LOAD;
                end
            end
            S_COMMIT: begin
                state_next = S_ENTRY;
                buf_clear  = 1'b1;
            end
            S_LOCK: begin
                if (timer_reg == 32'd0) begin
                    state_next    = S_ENTRY;
                    fail_cnt_next = '0;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end
            default: state_next = S_ENTRY;
        endcase
    end

    assign pwsin         = {buf_full, buf_word};
    assign current_state = state_code(state_reg);
    assign door_open     = (state_reg == S_OPEN) || (state_reg == S_CHG_ENTRY) ||
                           (state_reg == S_COMMIT);
    assign lockout       = (state_reg == S_LOCK);

endmodule

// File: tb/tb_pw_entry_ctrl.sv
// Self-checking bench for pw_entry_ctrl with a behavioural verifier and a
// queue-based reference model of the keypad front end.
module tb_pw_entry_ctrl;
    import doorlock_pkg::*;

    localparam int OPEN_C = 20;
    localparam int LOCK_C = 30;
    localparam int MAXF   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        pw_valid;
    logic [16:0] pwsin;
    logic [1:0]  current_state;
    logic        door_open;
    logic        lockout;
    logic [2:0]  digit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pw_entry_ctrl #(
        .OPEN_CYCLES (OPEN_C),
        .LOCK_CYCLES (LOCK_C),
        .MAX_FAIL    (MAXF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .pw_valid_in   (pw_valid),
        .pwsin         (pwsin),
        .current_state (current_state),
        .door_open     (door_open),
        .lockout       (lockout),
        .digit_cnt     (digit_cnt)
    );

    // Behavioural password_verifier: registered compare, loads on commit code.
    logic [15:0] ver_pw;
    initial ver_pw = DEFAULT_PW;
    initial pw_valid = 1'b0;
    always @(posedge clk) begin
        pw_valid <= (current_state == ST_VERIFY) && (pwsin[15:0] == ver_pw);
        if (current_state == ST_CHANGE) ver_pw <= pwsin[15:0];
    end

    // ---------------- reference model ----------------
    typedef enum {M_ENTRY, M_V1, M_V2, M_OPEN, M_CHG, M_COMMIT, M_LOCK} mphase_t;
    mphase_t     m_ph;
    int          m_q[$];
    int          m_fails;
    int          m_left;
    logic [15:0] m_pw;

    function automatic logic [15:0] qval();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_ph = M_ENTRY;
        m_q.delete();
        m_fails = 0;
        m_left = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc);
        case (m_ph)
            M_ENTRY, M_CHG: if (kv) begin
                if (kc <= 4'd9) begin
                    if (m_q.size() < 4) m_q.push_back(int'(kc));
                end else if (kc == KEY_CLEAR) begin
                    m_q.delete();
                end else if (kc == KEY_ENTER) begin
                    if (m_q.size() == 4) m_ph = (m_ph == M_ENTRY) ? M_V1 : M_COMMIT;
                    else m_q.delete();
                end else if (kc == KEY_CHANGE && m_ph == M_CHG) begin
                    m_q.delete();
                    m_ph = M_OPEN;
                    m_left = OPEN_C;
                end
            end
            M_V1: m_ph = M_V2;
            M_V2: begin
                if (qval() == m_pw) begin
                    m_ph = M_OPEN;
                    m_fails = 0;
                    m_left = OPEN_C;
                end else begin
                    m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
                    if (m_fails == MAXF) begin
                        m_ph = M_LOCK;
                        m_left = LOCK_C;
                    end else begin
                        m_ph = M_ENTRY;
                    end
                end
                m_q.delete();
            end
            M_OPEN: begin
                if (kv && kc == KEY_CHANGE) m_ph = M_CHG;
                else begin
                    m_left--;
                    if (m_left == 0) m_ph = M_ENTRY;
                end
            end
            M_COMMIT: begin
                m_pw = qval();
                m_q.delete();
                m_ph = M_ENTRY;
            end
            M_LOCK: begin
                m_left--;
                if (m_left == 0) begin
                    m_ph = M_ENTRY;
                    m_fails = 0;
                end
            end
            default: m_ph = M_ENTRY;
        endcase
    endtask

    function automatic logic [1:0] exp_cs();
        case (m_ph)
            M_V1, M_V2:     return 2'b01;
            M_OPEN, M_CHG:  return 2'b10;
            M_COMMIT:       return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mdl_pwsin", 32'(pwsin), 32'({(m_q.size() == 4), qval()}));
        check("mdl_state", 32'(current_state), 32'(exp_cs()));
        check("mdl_door", 32'(door_open), 32'((m_ph == M_OPEN) || (m_ph == M_CHG) || (m_ph == M_COMMIT)));
        check("mdl_lockout", 32'(lockout), 32'(m_ph == M_LOCK));
        check("mdl_digit_cnt", 32'(digit_cnt), 32'(m_q.size()));
    endtask

    // One clock: drive at posedge+1, advance model, sample at next posedge+1.
    task automatic cycle(input logic kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        model_step(kv, kc);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        compare_model();
    endtask

    task automatic type_pw(input logic [15:0] pw);
        for (int i = 3; i >= 0; i--) cycle(1'b1, pw[i*4 +: 4]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pwsin"}, 32'(pwsin), 32'd0);
        check({tag, "_state"}, 32'(current_state), 32'(ST_IDLE));
        check({tag, "_door"}, 32'(door_open), 32'd0);
        check({tag, "_lockout"}, 32'(lockout), 32'd0);
        check({tag, "_digit_cnt"}, 32'(digit_cnt), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic [16:0] pw;
        logic [1:0]  cs;
        logic        door;
        logic        lock;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic [16:0] pw,
                                input logic [1:0] cs, input logic door, input logic lock,
                                input logic [2:0] cnt);
        vec_t v;
        v.kv = kv; v.kc = kc; v.pw = pw; v.cs = cs; v.door = door; v.lock = lock; v.cnt = cnt;
        return v;
    endfunction

    int scr[$];

    initial begin
        int open_len;
        int lock_len;
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        m_pw      = DEFAULT_PW;
        model_reset();

        // 1234 ENTER opens, then change password to 5678 and try 12 ENTER / 1234.
        tbl.push_back(mk(1, 4'h1, 17'h00001, 2'b00, 0, 0, 3'd1));
        tbl.push_back(mk(1, 4'h2, 17'h00012, 2'b00, 0, 0, 3'd2));
        tbl.push_back(mk(1, 4'h3, 17'h00123, 2'b00, 0, 0, 3'd3));
        tbl.push_back(mk(1, 4'h4, 17'h11234, 2'b00, 0, 0, 3'd4));
        tbl.push_back(mk(1, KEY_ENTER, 17'h11234, 2'b01, 0, 0, 3'd4));
        tbl.push_back(mk(0, 4'h0, 17'h11234, 2'b01, 0, 0, 3'd4));
        tbl.push_back(mk(0, 4'h0, 17'h00000, 2'b10, 1, 0, 3'd0));
        tbl.push_back(mk(1, 4'h5, 17'h00000, 2'b10, 1, 0, 3'd0));
        tbl.push_back(mk(1, KEY_CHANGE, 17'h00000, 2'b10, 1, 0, 3'd0));
        tbl.push_back(mk(1, 4'h5, 17'h00005, 2'b10, 1, 0, 3'd1));
        tbl.push_back(mk(1, 4'h6, 17'h00056, 2'b10, 1, 0, 3'd2));
        tbl.push_back(mk(1, 4'h7, 17'h00567, 2'b10, 1, 0, 3'd3));
        tbl.push_back(mk(1, 4'h8, 17'h15678, 2'b10, 1, 0, 3'd4));
        tbl.push_back(mk(1, KEY_ENTER, 17'h15678, 2'b11, 1, 0, 3'd4));
        tbl.push_back(mk(0, 4'h0, 17'h00000, 2'b00, 0, 0, 3'd0));
        tbl.push_back(mk(1, 4'h1, 17'h00001, 2'b00, 0, 0, 3'd1));
        tbl.push_back(mk(1, 4'h2, 17'h00012, 2'b00, 0, 0, 3'd2));
        tbl.push_back(mk(1, KEY_ENTER, 17'h00000, 2'b00, 0, 0, 3'd0));
        tbl.push_back(mk(1, 4'h1, 17'h00001, 2'b00, 0, 0, 3'd1));
        tbl.push_back(mk(1, 4'h2, 17'h00012, 2'b00, 0, 0, 3'd2));
        tbl.push_back(mk(1, 4'h3, 17'h00123, 2'b00, 0, 0, 3'd3));
        tbl.push_back(mk(1, 4'h4, 17'h11234, 2'b00, 0, 0, 3'd4));
        tbl.push_back(mk(1, KEY_ENTER, 17'h11234, 2'b01, 0, 0, 3'd4));
        tbl.push_back(mk(0, 4'h0, 17'h11234, 2'b01, 0, 0, 3'd4));
        tbl.push_back(mk(0, 4'h0, 17'h00000, 2'b00, 0, 0, 3'd0));

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].kv, tbl[i].kc);
            check($sformatf("tbl%0d_pwsin", i), 32'(pwsin), 32'(tbl[i].pw));
            check($sformatf("tbl%0d_state", i), 32'(current_state), 32'(tbl[i].cs));
            check($sformatf("tbl%0d_door", i), 32'(door_open), 32'(tbl[i].door));
            check($sformatf("tbl%0d_lockout", i), 32'(lockout), 32'(tbl[i].lock));
            check($sformatf("tbl%0d_cnt", i), 32'(digit_cnt), 32'(tbl[i].cnt));
        end

        // Overflow digits dropped; door opens 3 cycles after ENTER for OPEN_C cycles.
        type_pw(16'h5678);
        cycle(1'b1, 4'h1);
        cycle(1'b1, 4'h2);
        check("overflow_pwsin", 32'(pwsin), 32'h15678);
        check("overflow_cnt", 32'(digit_cnt), 32'd4);
        cycle(1'b1, KEY_ENTER);
        cycle(1'b0, 4'h0);
        check("door_not_yet", 32'(door_open), 32'd0);
        cycle(1'b0, 4'h0);
        check("door_at_3", 32'(door_open), 32'd1);
        open_len = 1;
        for (int i = 0; i < OPEN_C + 5; i++) begin
            cycle(1'b0, 4'h0);
            if (door_open) open_len++;
        end
        check("open_len", 32'(open_len), 32'(OPEN_C));

        // Three consecutive failures lock out for LOCK_C cycles, keys ignored.
        for (int t = 1; t <= 3; t++) begin
            type_pw(16'h9999);
            cycle(1'b1, KEY_ENTER);
            cycle(1'b0, 4'h0);
            cycle(1'b0, 4'h0);
            check($sformatf("lock_after_fail%0d", t), 32'(lockout), 32'(t == 3));
        end
        lock_len = 1;
        for (int i = 0; i < LOCK_C + 5; i++) begin
            if (lockout) begin
                cycle(1'b1, 4'h9);
                if (lockout) begin
                    lock_len++;
                    check("lock_key_ignored", 32'(digit_cnt), 32'd0);
                end
            end else begin
                cycle(1'b0, 4'h0);
            end
        end
        check("lock_len", 32'(lock_len), 32'(LOCK_C));
        check("lock_released", 32'(lockout), 32'd0);

        // Asynchronous reset during VER2 clears outputs at once; password kept.
        type_pw(16'h5678);
        cycle(1'b1, KEY_ENTER);
        cycle(1'b0, 4'h0);
        check("in_ver2", 32'(current_state), 32'(ST_VERIFY));
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        type_pw(16'h5678);
        cycle(1'b1, KEY_ENTER);
        cycle(1'b0, 4'h0);
        cycle(1'b0, 4'h0);
        check("pw_kept_after_reset", 32'(door_open), 32'd1);

        // Randomised sessions against the reference model.
        for (int c = 0; c < 4000; c++) begin
            if (scr.size() == 0) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 40) begin
                    for (int i = 3; i >= 0; i--) scr.push_back(int'(m_pw[i*4 +: 4]));
                    scr.push_back(int'(KEY_ENTER));
                end else if (r < 60) begin
                    int n;
                    n = int'($urandom_range(0, 6));
                    for (int i = 0; i < n; i++) scr.push_back(int'($urandom_range(0, 9)));
                    scr.push_back(int'(KEY_ENTER));
                end else if (r < 72) begin
                    scr.push_back(int'(KEY_CHANGE));
                    for (int i = 0; i < 4; i++) scr.push_back(int'($urandom_range(0, 9)));
                    scr.push_back(int'(KEY_ENTER));
                end else if (r < 80) begin
                    scr.push_back(int'(KEY_CLEAR));
                end else begin
                    scr.push_back(int'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 4'h0);
            else cycle(1'b1, 4'(scr.pop_front()));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
